fifo_read_ctrl: RTL and testbench
=================================

FIFO_READ_CTRL -- requirements
Module: fifo_read_ctrl

Interface
REQ-001 The block SHALL take parameter ptr_size, default 4, meaning the pointer is ptr_size+1 bits and FIFO depth is 2^ptr_size.
REQ-002 The block SHALL take parameter aempty_thresh, default 2, meaning the almost-empty threshold in entries.
REQ-003 Port rd_clk, input, 1 bit: read-domain clock; the block has one clock and reset is synchronous and active-high.
REQ-004 Port rst, input, 1 bit: synchronous active-high reset, sampled on rising rd_clk.
REQ-005 Port g_wptr_async, input, ptr_size+1 bits: Gray write pointer from the write domain, not synchronized.
REQ-006 Port rd_en, input, 1 bit: read request.
REQ-007 Port empty, output, 1 bit: FIFO empty, registered.
REQ-008 Port aempty, output, 1 bit: almost-empty, registered.
REQ-009 Port rd_count, output, ptr_size+1 bits: read-side occupancy, registered.
REQ-010 Port underflow, output, 1 bit: sticky flag for a read attempted while empty.
REQ-011 Port b_rptr, output, ptr_size+1 bits: binary read pointer; bits [ptr_size-1:0] are the memory read address.
REQ-012 Port g_rptr, output, ptr_size+1 bits: Gray read pointer, registered, sent to the write domain.
REQ-013 Port mem_rd_en, output, 1 bit: combinational memory read strobe.

Function
REQ-014 g_wptr_async SHALL pass through a two-flop synchronizer, giving g_wptr_sync 2 rd_clk edges later.
REQ-015 g_wptr_sync SHALL be converted combinationally to binary b_wptr_sync: bit i = XOR of Gray bits [ptr_size:i].
REQ-016 rd_fire SHALL equal rd_en AND NOT empty; mem_rd_en SHALL equal rd_fire.
REQ-017 b_rptr_next SHALL equal b_rptr + rd_fire, modulo 2^(ptr_size+1).
REQ-018 g_rptr_next SHALL equal (b_rptr_next >> 1) XOR b_rptr_next.
REQ-019 On each edge, b_rptr SHALL load b_rptr_next and g_rptr SHALL load g_rptr_next.
REQ-020 empty SHALL be registered as (g_rptr_next == g_wptr_sync), so the last read sets empty on its own edge with no extra read.
REQ-021 rd_count SHALL be registered as (b_wptr_sync - b_rptr_next) modulo 2^(ptr_size+1); its maximum is 2^ptr_size.
REQ-022 aempty SHALL be registered as (rd_count_next <= aempty_thresh).
REQ-023 If rd_en is high while empty is high, the block SHALL leave b_rptr and g_rptr unchanged, hold mem_rd_en low, and set underflow; only rst clears underflow.
REQ-024 The pointer SHALL wrap from 2^(ptr_size+1)-1 to 0; the MSB toggles every 2^ptr_size reads.
REQ-025 Because the write pointer arrives late through the synchronizer, empty and rd_count SHALL be pessimistic: they may show fewer entries than are present, never more.
REQ-026 A write-pointer change and a read in the same cycle SHALL both be reflected in the next registered empty and rd_count.

Reset
REQ-027 When rst is high at an edge, the block SHALL set b_rptr=0, g_rptr=0, both synchronizer flops=0, rd_count=0, empty=1, aempty=1, underflow=0.
REQ-028 Reset asserted mid-operation SHALL override any read in that cycle, and mem_rd_en SHALL be low while rst is high.

Structure
REQ-029 A shared package SHALL hold the default ptr_size and a bin2gray function; gray2bin MAY be placed there too.
REQ-030 The two-flop synchronizer SHALL be a separate sub-module, sync_2ff, with a width parameter and synchronous reset.

Verification (ptr_size=4, aempty_thresh=2)
REQ-031 Reset scenario: pulse rst for 1 cycle -> empty=1, aempty=1, rd_count=0, b_rptr=0, g_rptr=0, underflow=0.
REQ-032 Sync-latency scenario: drive g_wptr_async=5'b00010 (binary 3) -> empty=0 and rd_count=3 after the 3rd edge; then 3 reads -> b_rptr=3, g_rptr=5'b00010, and empty=1 on the 3rd read edge.
REQ-033 Underflow scenario: rd_en=1 while empty -> b_rptr unchanged, mem_rd_en=0, underflow=1 and held through later valid reads until rst.
REQ-034 Threshold scenario: rd_count=3 gives aempty=0; one read -> rd_count=2 and aempty=1.
REQ-035 Wrap scenario: write pointer at binary 16 (Gray 5'b11000) -> rd_count=16; 16 reads -> b_rptr=5'b10000, g_rptr=5'b11000, empty=1; advance write to 32 (=0) and read 16 -> b_rptr=0.
REQ-036 Mid-operation reset scenario: assert rst while rd_en=1 and rd_count=5 -> at the next edge all outputs are at reset values and no pointer increment occurs.

Source files
------------

// File: rtl/fifo_read_ctrl_pkg.sv
// Shared definitions for the async FIFO read-side controller: default sizing
// and Gray/binary pointer conversion helpers.
package fifo_read_ctrl_pkg;

    localparam int DEFAULT_PTR_SIZE      = 4;
    localparam int DEFAULT_AEMPTY_THRESH = 2;
    localparam int CODE_W                = 32;

    function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] bin);
        return {1'b0, bin[CODE_W-1:1]} ^ bin;
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above it; callers
    // zero-extend narrower pointers, so the unused upper bits contribute nothing.
    function automatic logic [CODE_W-1:0] gray2bin(input logic [CODE_W-1:0] gray);
        logic [CODE_W-1:0] bin;
        bin[CODE_W-1] = gray[CODE_W-1];
        for (int i = CODE_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_read_ctrl_sync.sv
// Two-flop synchronizer bringing a Gray-coded bus into the local clock domain.
module sync_2ff #(
    parameter int width = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    logic [width-1:0] meta_r;

    // Two-stage capture; the first stage may go metastable, the second settles it.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= '0;
            q      <= '0;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side controller of an asynchronous FIFO: read pointer, empty/almost-empty
// flags, occupancy and sticky underflow, all judged against the synchronized write pointer.
module fifo_read_ctrl
    import fifo_read_ctrl_pkg::*;
#(
    parameter int ptr_size      = DEFAULT_PTR_SIZE,
    parameter int aempty_thresh = DEFAULT_AEMPTY_THRESH
) (
    input  logic              rd_clk,
    input  logic              rst,
    input  logic [ptr_size:0] g_wptr_async,
    input  logic              rd_en,
    output logic              empty,
    output logic              aempty,
    output logic [ptr_size:0] rd_count,
    output logic              underflow,
    output logic [ptr_size:0] b_rptr,
    output logic [ptr_size:0] g_rptr,
    output logic              mem_rd_en
);

    localparam int               PTR_W           = ptr_size + 1;
    localparam logic [PTR_W-1:0] AEMPTY_THRESH_C = PTR_W'(aempty_thresh);

    logic [PTR_W-1:0] g_wptr_sync_s;
    logic [PTR_W-1:0] b_wptr_sync_s;
    logic [PTR_W-1:0] b_rptr_next_s;
    logic [PTR_W-1:0] g_rptr_next_s;
    logic [PTR_W-1:0] rd_count_next_s;
    logic             rd_fire_s;

    sync_2ff #(
        .width(PTR_W)
    ) u_wptr_sync (
        .clk (rd_clk),
        .rst (rst),
        .d   (g_wptr_async),
        .q   (g_wptr_sync_s)
    );

    // Next-state pointer arithmetic; reset suppresses the read so the memory never sees a strobe.
    always_comb begin
        b_wptr_sync_s   = PTR_W'(gray2bin(CODE_W'(g_wptr_sync_s)));
        rd_fire_s       = rd_en & ~empty & ~rst;
        b_rptr_next_s   = b_rptr + {{(PTR_W-1){1'b0}}, rd_fire_s};
        g_rptr_next_s   = PTR_W'(bin2gray(CODE_W'(b_rptr_next_s)));
        rd_count_next_s = b_wptr_sync_s - b_rptr_next_s;
    end

    assign mem_rd_en = rd_fire_s;

    // Flags use the post-read pointer so the final read raises empty on its own edge.
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            b_rptr    <= '0;
            g_rptr    <= '0;
            empty     <= 1'b1;
            aempty    <= 1'b1;
            rd_count  <= '0;
            underflow <= 1'b0;
        end else begin
            b_rptr    <= b_rptr_next_s;
            g_rptr    <= g_rptr_next_s;
            empty     <= (g_rptr_next_s == g_wptr_sync_s);
            aempty    <= (rd_count_next_s <= AEMPTY_THRESH_C);
            rd_count  <= rd_count_next_s;
            underflow <= underflow | (rd_en & empty);
        end
    end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Self-checking bench for fifo_read_ctrl: directed vector table, hand-written
// wrap/reset sequences, and randomized traffic against an occupancy-based model.
module tb_fifo_read_ctrl;

    localparam int W     = 5;
    localparam int MOD   = 32;
    localparam int DEPTH = 16;
    localparam int AE    = 2;

    logic         rd_clk = 1'b0;
    logic         rst;
    logic         rd_en;
    logic [W-1:0] g_wptr_async;
    logic         empty;
    logic         aempty;
    logic [W-1:0] rd_count;
    logic         underflow;
    logic [W-1:0] b_rptr;
    logic [W-1:0] g_rptr;
    logic         mem_rd_en;

    int errors = 0;
    int checks = 0;

    fifo_read_ctrl #(
        .ptr_size      (4),
        .aempty_thresh (2)
    ) dut (
        .rd_clk       (rd_clk),
        .rst          (rst),
        .g_wptr_async (g_wptr_async),
        .rd_en        (rd_en),
        .empty        (empty),
        .aempty       (aempty),
        .rd_count     (rd_count),
        .underflow    (underflow),
        .b_rptr       (b_rptr),
        .g_rptr       (g_rptr),
        .mem_rd_en    (mem_rd_en)
    );

    always #5 rd_clk = ~rd_clk;

    typedef struct {
        logic         r;
        logic         rd;
        int           wbin;
        logic         x_mem;
        logic         x_empty;
        logic         x_aempty;
        int           x_cnt;
        logic         x_uf;
        int           x_b;
        logic [W-1:0] x_g;
    } vec_t;

    vec_t tbl [14];

    function automatic logic [W-1:0] to_gray(input int b);
        int v;
        v = b % MOD;
        return W'(v ^ (v / 2));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, check the combinational strobe, then step past the edge.
    task automatic apply(input logic r, input logic rd, input int wbin, input logic x_mem);
        rst          = r;
        rd_en        = rd;
        g_wptr_async = to_gray(wbin);
        #1;
        chk("mem_rd_en", {31'd0, mem_rd_en}, {31'd0, x_mem});
        @(posedge rd_clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic xe, input logic xa, input int xc,
                             input logic xu, input int xb, input logic [W-1:0] xg);
        chk({tag, ".empty"},     {31'd0, empty},     {31'd0, xe});
        chk({tag, ".aempty"},    {31'd0, aempty},    {31'd0, xa});
        chk({tag, ".rd_count"},  {27'd0, rd_count},  xc);
        chk({tag, ".underflow"}, {31'd0, underflow}, {31'd0, xu});
        chk({tag, ".b_rptr"},    {27'd0, b_rptr},    xb);
        chk({tag, ".g_rptr"},    {27'd0, g_rptr},    {27'd0, xg});
    endtask

    initial begin
        int m_r, m_cnt, d0, d1, wtot, rtot;
        logic m_empty, m_aempty, m_uf, r, rd, x_mem;

        // r, rd, wbin, mem | empty, aempty, rd_count, underflow, b_rptr, g_rptr
        tbl[0]  = '{1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 0, 5'b00000};
        tbl[1]  = '{1'b0, 1'b0, 3, 1'b0, 1'b1, 1'b1, 0, 1'b0, 0, 5'b00000};
        tbl[2]  = '{1'b0, 1'b0, 3, 1'b0, 1'b1, 1'b1, 0, 1'b0, 0, 5'b00000};
        tbl[3]  = '{1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 3, 1'b0, 0, 5'b00000};
        tbl[4]  = '{1'b0, 1'b1, 3, 1'b1, 1'b0, 1'b1, 2, 1'b0, 1, 5'b00001};
        tbl[5]  = '{1'b0, 1'b1, 3, 1'b1, 1'b0, 1'b1, 1, 1'b0, 2, 5'b00011};
        tbl[6]  = '{1'b0, 1'b1, 3, 1'b1, 1'b1, 1'b1, 0, 1'b0, 3, 5'b00010};
        tbl[7]  = '{1'b0, 1'b1, 3, 1'b0, 1'b1, 1'b1, 0, 1'b1, 3, 5'b00010};
        tbl[8]  = '{1'b0, 1'b0, 5, 1'b0, 1'b1, 1'b1, 0, 1'b1, 3, 5'b00010};
        tbl[9]  = '{1'b0, 1'b0, 5, 1'b0, 1'b1, 1'b1, 0, 1'b1, 3, 5'b00010};
        tbl[10] = '{1'b0, 1'b0, 5, 1'b0, 1'b0, 1'b1, 2, 1'b1, 3, 5'b00010};
        tbl[11] = '{1'b0, 1'b1, 5, 1'b1, 1'b0, 1'b1, 1, 1'b1, 4, 5'b00110};
        tbl[12] = '{1'b1, 1'b1, 5, 1'b0, 1'b1, 1'b1, 0, 1'b0, 0, 5'b00000};
        tbl[13] = '{1'b0, 1'b0, 5, 1'b0, 1'b1, 1'b1, 0, 1'b0, 0, 5'b00000};

        for (int i = 0; i < 14; i++) begin
            apply(tbl[i].r, tbl[i].rd, tbl[i].wbin, tbl[i].x_mem);
            check_all($sformatf("vec%0d", i), tbl[i].x_empty, tbl[i].x_aempty, tbl[i].x_cnt,
                      tbl[i].x_uf, tbl[i].x_b, tbl[i].x_g);
        end

        // Wrap: fill to 16, drain 16, advance write to 32 (== 0), drain 16 more.
        apply(1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i < 3; i++) apply(1'b0, 1'b0, 16, 1'b0);
        check_all("wrap_full", 1'b0, 1'b0, 16, 1'b0, 0, 5'b00000);
        for (int i = 0; i < 16; i++) apply(1'b0, 1'b1, 16, 1'b1);
        check_all("wrap_half", 1'b1, 1'b1, 0, 1'b0, 16, 5'b11000);
        for (int i = 0; i < 3; i++) apply(1'b0, 1'b0, 32, 1'b0);
        check_all("wrap_refill", 1'b0, 1'b0, 16, 1'b0, 16, 5'b11000);
        for (int i = 0; i < 16; i++) apply(1'b0, 1'b1, 32, 1'b1);
        check_all("wrap_done", 1'b1, 1'b1, 0, 1'b0, 0, 5'b00000);

        // Reset arriving together with a read at rd_count=5.
        for (int i = 0; i < 3; i++) apply(1'b0, 1'b0, 6, 1'b0);
        apply(1'b0, 1'b1, 6, 1'b1);
        check_all("mid_pre", 1'b0, 1'b0, 5, 1'b0, 1, 5'b00001);
        apply(1'b1, 1'b1, 6, 1'b0);
        check_all("mid_rst", 1'b1, 1'b1, 0, 1'b0, 0, 5'b00000);

        // Random traffic: the model tracks reads, the write count seen two edges late, and occupancy.
        m_r = 0; m_cnt = 0; d0 = 0; d1 = 0; wtot = 0; rtot = 0;
        m_empty = 1'b1; m_aempty = 1'b1; m_uf = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            r  = (i == 0) || ($urandom_range(0, 149) == 0);
            rd = 1'($urandom_range(0, 1));
            if (r) begin
                wtot = 0;
                rtot = 0;
            end else if ($urandom_range(0, 1) == 1 && (wtot - rtot) < DEPTH) begin
                wtot++;
            end
            x_mem = rd && !m_empty && !r;
            apply(r, rd, wtot, x_mem);
            if (r) begin
                m_r = 0; d0 = 0; d1 = 0; m_cnt = 0;
                m_empty = 1'b1; m_aempty = 1'b1; m_uf = 1'b0;
            end else begin
                if (rd && m_empty) m_uf = 1'b1;
                if (x_mem) begin
                    m_r = (m_r + 1) % MOD;
                    rtot++;
                end
                m_cnt    = (d0 - m_r + MOD) % MOD;
                m_empty  = (m_cnt == 0);
                m_aempty = (m_cnt <= AE);
                d0       = d1;
                d1       = wtot % MOD;
            end
            check_all("rand", m_empty, m_aempty, m_cnt, m_uf, m_r, W'(m_r ^ (m_r / 2)));
            chk("rand.pessimistic", {31'd0, (int'(rd_count) <= (wtot - rtot))}, 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
